led_pwm: RTL and testbench

Memory-mapped LED peripheral sitting directly downstream of the system bus decoder on the `led` follower port (region 0x1xxx_xxxx). It holds a two-register file, reachable through address bit 0 only, since the decoder masks the address. It drives up to eight LED pins from a pattern register gated by a prescaled 8-bit PWM generator.

---
 rtl/led_pwm.sv | 120 ++++++++++++
 tb/tb_led_pwm.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm.sv
// led_pwm: memory-mapped LED peripheral with a prescaled 8-bit PWM gate.
//
// Two word registers, selected by address bit 0 only:
//   CTRL (0): [7:0] pattern (NUM_LEDS LSBs stored), [8] enable
//   PWM  (1): [7:0] duty, [15:8] pwm_cnt (read-only), [31:16] prescale
//
// Ports:
//   clk                   system clock, rising edge
//   rst                   asynchronous active-high reset
//   i_bus_addr            word select, bit 0 decoded
//   i_bus_write_data      write payload
//   i_bus_byte_enable     per-byte write strobes
//   i_bus_read_req        single-cycle read request
//   i_bus_write_req       single-cycle write request
//   o_bus_read_data       read payload, 0 when not valid
//   o_bus_read_data_valid one-cycle pulse, one cycle after read_req
//   o_led                 registered LED drive, 1 = on
module led_pwm #(
    parameter int NUM_LEDS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         i_bus_addr,
    input  logic [31:0]         i_bus_write_data,
    input  logic [3:0]          i_bus_byte_enable,
    input  logic                i_bus_read_req,
    input  logic                i_bus_write_req,
    output logic [31:0]         o_bus_read_data,
    output logic                o_bus_read_data_valid,
    output logic [NUM_LEDS-1:0] o_led
);

    logic [NUM_LEDS-1:0] r_pattern;
    logic                r_enable;
    logic [7:0]          r_duty;
    logic [15:0]         r_prescale;
    logic [15:0]         r_pre_cnt;
    logic [7:0]          r_pwm_cnt;
    logic [NUM_LEDS-1:0] r_led;
    logic [31:0]         r_rdata;
    logic                r_rvalid;

    logic                w_ctrl_wr;
    logic                w_pwm_wr;
    logic                w_pre_clr;
    logic                w_step;
    logic                w_pwm_on;
    logic [7:0]          w_pat_ext;
    logic [31:0]         w_rd_val;

    // The decoder masks the address, so only bit 0 matters; write_data[15:9]
    // has no stored field behind it.
    logic w_unused_bits;
    assign w_unused_bits = ^{i_bus_addr[31:1], i_bus_write_data[15:9]};

    assign w_ctrl_wr = i_bus_write_req & ~i_bus_addr[0];
    assign w_pwm_wr  = i_bus_write_req &  i_bus_addr[0];
    // Touching either prescale byte restarts the current PWM step.
    assign w_pre_clr = w_pwm_wr & (i_bus_byte_enable[2] | i_bus_byte_enable[3]);
    assign w_step    = (r_pre_cnt == r_prescale);
    assign w_pwm_on  = (r_pwm_cnt < r_duty);

    always_comb begin
        w_pat_ext = '0;
        w_pat_ext[NUM_LEDS-1:0] = r_pattern;
    end

    assign w_rd_val = i_bus_addr[0] ? {r_prescale, r_pwm_cnt, r_duty}
                                    : {23'd0, r_enable, w_pat_ext};

    // Register file writes, byte-lane granular.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pattern  <= '0;
            r_enable   <= 1'b0;
            r_duty     <= '0;
            r_prescale <= '0;
        end else begin
            if (w_ctrl_wr && i_bus_byte_enable[0]) r_pattern  <= i_bus_write_data[NUM_LEDS-1:0];
            if (w_ctrl_wr && i_bus_byte_enable[1]) r_enable   <= i_bus_write_data[8];
            if (w_pwm_wr  && i_bus_byte_enable[0]) r_duty     <= i_bus_write_data[7:0];
            if (w_pwm_wr  && i_bus_byte_enable[2]) r_prescale[7:0]  <= i_bus_write_data[23:16];
            if (w_pwm_wr  && i_bus_byte_enable[3]) r_prescale[15:8] <= i_bus_write_data[31:24];
        end
    end

    // Prescaler and PWM counter. A prescale write clears pre_cnt but does not
    // suppress a pwm_cnt step that falls on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else if (!r_enable) begin
            r_pre_cnt <= '0;
            r_pwm_cnt <= '0;
        end else begin
            r_pre_cnt <= w_step ? 16'd0 : r_pre_cnt + 16'd1;
            if (w_step)    r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (w_pre_clr) r_pre_cnt <= '0;
        end
    end

    // LED drive and read return path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led    <= '0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_led    <= r_enable ? (r_pattern & {NUM_LEDS{w_pwm_on}}) : r_pattern;
            r_rvalid <= i_bus_read_req;
            r_rdata  <= i_bus_read_req ? w_rd_val : 32'd0;
        end
    end

    assign o_led                 = r_led;
    assign o_bus_read_data       = r_rdata;
    assign o_bus_read_data_valid = r_rvalid;

endmodule

// File: tb/tb_led_pwm.sv
// Self-checking bench for led_pwm: a directed vector table, hand sequences
// for the PWM timing corners and reset, then randomized traffic compared
// every cycle against a register-file level model.
module tb_led_pwm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] rdata, rdata4;
    logic        rvalid, rvalid4;
    logic [7:0]  led;
    logic [3:0]  led4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    led_pwm #(.NUM_LEDS(8)) u_dut (
        .clk(clk), .rst(rst), .i_bus_addr(addr), .i_bus_write_data(wdata),
        .i_bus_byte_enable(be), .i_bus_read_req(rd), .i_bus_write_req(wr),
        .o_bus_read_data(rdata), .o_bus_read_data_valid(rvalid), .o_led(led));

    led_pwm #(.NUM_LEDS(4)) u_dut4 (
        .clk(clk), .rst(rst), .i_bus_addr(addr), .i_bus_write_data(wdata),
        .i_bus_byte_enable(be), .i_bus_read_req(rd), .i_bus_write_req(wr),
        .o_bus_read_data(rdata4), .o_bus_read_data_valid(rvalid4), .o_led(led4));

    // ---------------- reference model (8-LED build) ----------------
    // Registers kept as two plain 32-bit words with a writable-bit mask;
    // pwm_cnt lives outside the word and is merged in on read.
    logic [31:0] m_regs [2];
    logic [31:0] m_wmask [2];
    int          m_pre, m_pwm;
    logic [7:0]  m_led;
    logic [31:0] m_rdata;
    logic        m_rvalid;

    task automatic model_reset();
        m_regs[0] = 0; m_regs[1] = 0;
        m_pre = 0; m_pwm = 0; m_led = 0; m_rdata = 0; m_rvalid = 0;
    endtask

    task automatic model_edge();
        logic [31:0] mask;
        logic [7:0]  pat, duty;
        logic        en;
        int          presc, a;
        if (rst) begin model_reset(); return; end
        a     = int'(addr[0]);
        pat   = m_regs[0][7:0];
        en    = m_regs[0][8];
        duty  = m_regs[1][7:0];
        presc = int'(m_regs[1][31:16]);
        m_led    = (en && !(m_pwm < int'(duty))) ? 8'h00 : pat;
        m_rvalid = rd;
        m_rdata  = !rd ? 32'd0 : (a == 1) ? (m_regs[1] | (32'(m_pwm) << 8)) : m_regs[0];
        if (!en) begin
            m_pre = 0; m_pwm = 0;
        end else if (m_pre == presc) begin
            m_pre = 0; m_pwm = (m_pwm + 1) % 256;
        end else begin
            m_pre = m_pre + 1;
        end
        if (wr && a == 1 && (be[2] || be[3])) m_pre = 0;
        if (wr) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}} & m_wmask[a];
            m_regs[a] = (m_regs[a] & ~mask) | (wdata & mask);
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("led", {24'd0, led}, {24'd0, m_led});
        chk("rvalid", {31'd0, rvalid}, {31'd0, m_rvalid});
        chk("rdata", rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        rd = 0; wr = 0; be = 0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic bus_wr(input logic a, input logic [31:0] d, input logic [3:0] b);
        addr = {31'd0, a}; wdata = d; be = b; wr = 1; rd = 0;
        cycle();
        wr = 0; be = 0;
    endtask

    task automatic bus_rd(input logic a, output logic [31:0] d);
        addr = {31'd0, a}; rd = 1; wr = 0;
        cycle();
        rd = 0;
        d = rdata;
    endtask

    typedef struct {
        logic        wr, rd, a;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] d0, d1;
        int on_cnt, off_cnt, changes;
        logic [7:0] prev;

        m_wmask[0] = 32'h0000_01FF;
        m_wmask[1] = 32'hFFFF_00FF;
        model_reset();

        //           wr rd a  wdata          be    expected read
        tbl[0]  = '{0, 1, 0, 32'h0,         4'h0, 32'h0000_0000};
        tbl[1]  = '{0, 1, 1, 32'h0,         4'h0, 32'h0000_0000};
        tbl[2]  = '{1, 0, 1, 32'h1234_00AB, 4'h5, 32'h0};
        tbl[3]  = '{0, 1, 1, 32'h0,         4'h0, 32'h0034_00AB};
        tbl[4]  = '{1, 0, 0, 32'h0000_00A5, 4'hF, 32'h0};
        tbl[5]  = '{0, 1, 0, 32'h0,         4'h0, 32'h0000_00A5};
        tbl[6]  = '{1, 0, 0, 32'hFFFF_FFFF, 4'h1, 32'h0};
        tbl[7]  = '{0, 1, 0, 32'h0,         4'h0, 32'h0000_00FF};
        tbl[8]  = '{1, 0, 0, 32'h0,         4'h0, 32'h0};
        tbl[9]  = '{0, 1, 0, 32'h0,         4'h0, 32'h0000_00FF};
        tbl[10] = '{1, 0, 1, 32'hFFFF_FFFF, 4'h2, 32'h0};
        tbl[11] = '{0, 1, 1, 32'h0,         4'h0, 32'h0034_00AB};
        tbl[12] = '{1, 0, 1, 32'hBEEF_0000, 4'hC, 32'h0};
        tbl[13] = '{0, 1, 1, 32'h0,         4'h0, 32'hBEEF_00AB};
        tbl[14] = '{1, 0, 0, 32'h0000_000F, 4'h1, 32'h0};
        tbl[15] = '{1, 1, 0, 32'h0000_00F0, 4'h1, 32'h0000_000F};
        tbl[16] = '{0, 1, 0, 32'h0,         4'h0, 32'h0000_00F0};

        // Power-on reset
        idle(2);
        chk("reset_led", {24'd0, led}, 32'd0);
        rst = 0;

        // Directed table (enable stays 0, so pwm_cnt reads 0)
        for (int i = 0; i < 17; i++) begin
            addr = {31'd0, tbl[i].a}; wdata = tbl[i].wd; be = tbl[i].be;
            wr = tbl[i].wr; rd = tbl[i].rd;
            cycle();
            wr = 0; rd = 0; be = 0;
            if (tbl[i].rd) begin
                chk("tbl_rvalid", {31'd0, rvalid}, 32'd1);
                chk("tbl_rdata", rdata, tbl[i].exp);
                chk("tbl_rdata_4led", rdata4,
                    tbl[i].a ? tbl[i].exp : (tbl[i].exp & 32'hFFFF_FF0F));
            end
        end

        // Static drive: led follows two cycles after the write
        bus_wr(0, 32'h0000_00A5, 4'hF);
        idle(1);
        chk("static_led", {24'd0, led}, 32'hA5);
        idle(5);
        chk("static_led_hold", {24'd0, led}, 32'hA5);
        bus_rd(1, d0);
        chk("static_pwm_cnt", {24'd0, d0[15:8]}, 32'd0);

        // Duty 64 at prescale 0
        bus_wr(1, 32'h0000_0040, 4'hF);
        bus_wr(0, 32'h0000_01FF, 4'hF);
        idle(3);
        on_cnt = 0; off_cnt = 0; changes = 0; prev = led;
        for (int i = 0; i < 256; i++) begin
            cycle();
            if (led == 8'hFF) on_cnt++;
            else if (led == 8'h00) off_cnt++;
            if (i > 0 && led != prev) changes++;
            prev = led;
        end
        chk("duty64_on", on_cnt, 64);
        chk("duty64_off", off_cnt, 192);
        chk("duty64_single_run", {31'd0, changes <= 2}, 32'd1);

        // Duty 0: never on
        bus_wr(1, 32'h0, 4'h1);
        idle(2);
        on_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (led != 8'h00) on_cnt++;
        end
        chk("duty0_on", on_cnt, 0);

        // Prescale 3, duty 1
        bus_wr(1, 32'h0003_0001, 4'hF);
        idle(1);
        bus_rd(1, d0);
        idle(3);
        bus_rd(1, d1);
        chk("presc_step", {24'd0, d1[15:8] - d0[15:8]}, 32'd1);
        on_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            cycle();
            if (led == 8'hFF) on_cnt++;
        end
        chk("presc_on_per_1024", on_cnt, 4);
        bus_rd(1, d0);
        idle(1023);
        bus_rd(1, d1);
        chk("presc_wrap", {24'd0, d1[15:8]}, {24'd0, d0[15:8]});

        // Mid-run asynchronous reset with a read pulse in flight
        bus_wr(1, 32'h0000_00FF, 4'hF);
        idle(3);
        addr = 0; rd = 1;
        cycle();
        rd = 0;
        rst = 1;
        #1;
        chk("async_rst_led", {24'd0, led}, 32'd0);
        chk("async_rst_rvalid", {31'd0, rvalid}, 32'd0);
        cycle();
        rst = 0;
        bus_rd(0, d0);
        chk("post_rst_ctrl", d0, 32'd0);
        bus_rd(1, d1);
        chk("post_rst_pwm", d1, 32'd0);

        // Randomized traffic vs. model
        for (int i = 0; i < 4000; i++) begin
            addr  = $urandom;
            wdata = $urandom;
            if ($urandom_range(0, 3) != 0) wdata[31:16] = 16'($urandom_range(0, 3));
            be = 4'($urandom);
            rd = ($urandom_range(0, 2) == 0);
            wr = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
